uart_tx_msg_arbiter: RTL and testbench
======================================

// Module: uart_tx_msg_arbiter
// PURPOSE
//  Shares one uart_tx byte transmitter among NUM_REQ message sources (SpO2/HR reporter, water-temp, pump status, ...).
//  Each source streams one ASCII message as bytes with a last flag. The arbiter grants sources round-robin and
//  locks the grant for a whole message, so lines never interleave. Sits between source formatters and uart_tx.
// PARAMETERS
//  NUM_REQ      4      number of requesting sources (2..8)
//  IDW          2      grant index width, = clog2(NUM_REQ)
//  TIMEOUT_CYC  33000  idle cycles allowed mid-message before grant is revoked (1 ms @ 33 MHz)
// PORTS
//  clk           in   1        system clock
//  rst_n         in   1        asynchronous active-low reset
//  req_valid     in   NUM_REQ  per-source byte valid
//  req_data      in   8*NUM_REQ per-source byte, source i at [8*i+7:8*i]
//  req_last      in   NUM_REQ  per-source: current byte ends the message
//  req_ready     out  NUM_REQ  per-source: byte accepted this cycle (valid&ready)
//  tx_data       out  8        byte to uart_tx
//  tx_data_valid out  1        byte present; held until accepted
//  tx_data_ready in   1        uart_tx idle; transfer = tx_data_valid & tx_data_ready
//  grant_id      out  IDW      current/last granted source
//  busy          out  1        state != IDLE
//  msg_done      out  1        1-cycle pulse: last byte of a message accepted by uart_tx
//  timeout_err   out  1        1-cycle pulse: grant revoked by timeout
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, holding reg empty, timeout counter 0.
//  States: IDLE -> XFER -> (DRAIN) -> IDLE.
//  IDLE: if any req_valid, pick winner = first set bit searching from rr_ptr upward with wrap; register
//    grant_id, enter XFER next edge. req_ready all 0 in IDLE. No request -> stay IDLE.
//  XFER: one-byte holding reg. req_ready[grant_id] = hold_empty (combinational); other ready bits 0.
//    On req_valid[g] & req_ready[g]: capture data+last, hold_full=1.
//    tx_data_valid = hold_full; tx_data = held byte. On tx transfer hold clears; same-cycle capture of
//    next byte allowed only when hold is empty at the start of the cycle (no bypass; max 1 byte per 2 cycles, ok vs baud).
//    If the captured byte had last=1: stop accepting (ready 0), go DRAIN.
//  DRAIN: wait for transfer of held last byte -> msg_done pulse, rr_ptr <= grant_id+1 (wrap at NUM_REQ), IDLE.
//  Latency: req_valid rise in IDLE at cycle 0 -> grant cycle 1 -> capture at end of cycle 1 -> tx_data_valid cycle 2.
//  Timeout: in XFER with hold empty and req_valid[g]=0, counter increments; reset on any capture.
//    counter == TIMEOUT_CYC-1 -> timeout_err pulse, rr_ptr <= g+1, IDLE. Held byte (if any) is still drained first.
//  Simultaneous requests: strict round-robin; source just served has lowest priority next arbitration.
//  Requests from non-granted sources are ignored (never dropped by arbiter; source holds valid).
//  req_valid of granted source dropping mid-message is legal (gap), subject to timeout only.
//  Reset mid-message: immediate abort, tx_data_valid 0 asynchronously; partial line is not resumed.
//  Counter width clog2(TIMEOUT_CYC+1); rr_ptr wraps explicitly, not by width overflow (NUM_REQ non-power-of-2 legal).
// STRUCTURE
//  fish_tank_uart_pkg: state encoding (IDLE/XFER/DRAIN), ASCII constants (CR 8'h0D, LF 8'h0A, ':' 8'h3A),
//    default NUM_REQ/TIMEOUT_CYC.
//  Sub-module rr_pick: combinational round-robin picker (req vector, rr_ptr -> winner idx, any).
//  Top holds FSM, holding reg, timeout counter, pointer.
// TESTING
//  1 single source 0 sends "SpO2:097%\r\n" (11 bytes, last on 0x0A) -> uart_tx receives identical bytes, one msg_done.
//  2 sources 0,2 valid together after reset -> source 0 full message first, then source 2; grant_id 0 then 2.
//  3 source 1 sends back-to-back messages while 3 waits -> 1,3,1 order (no starvation).
//  4 granted source stops after 3 bytes -> timeout_err exactly TIMEOUT_CYC cycles after last capture, busy drops,
//    next source granted.
//  5 tx_data_ready held low 500 cycles mid-message -> tx_data_valid/tx_data stable, no byte lost, no timeout.
//  6 rst_n asserted during byte 5 -> all outputs 0 immediately; after release new message starts cleanly from byte 0.

Source files
------------

// File: rtl/fish_tank_uart_pkg.sv
// Shared types and constants for the fish-tank UART reporting path.
// Holds the arbiter state encoding, ASCII framing bytes and default sizing.
package fish_tank_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_TIMEOUT_CYC = 33000;

endpackage

// File: rtl/uart_tx_msg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
// rr_ptr is expected to stay below NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [IDW-1:0]     winner,
    output logic               any
);

    logic [IDW-1:0] idx_s;

    // Scan from the pointer upward with wrap; the first hit wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx_s  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any && req[idx_s]) begin
                any    = 1'b1;
                winner = idx_s;
            end else begin
                any    = any;
            end
        end
    end

endmodule

// File: rtl/uart_tx_msg_arbiter.sv
// Shares one uart_tx byte transmitter among NUM_REQ message sources, locking the
// grant for a whole message (up to the byte flagged last) with an idle timeout.
module uart_tx_msg_arbiter
    import fish_tank_uart_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int IDW         = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    input  logic                 tx_data_ready,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic                 msg_done,
    output logic                 timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    arb_state_e     state_r, state_nxt_s;
    logic [IDW-1:0] grant_r, grant_nxt_s;
    logic [IDW-1:0] rr_ptr_r, rr_ptr_nxt_s;
    logic [IDW-1:0] grant_inc_s, pick_idx_s;
    logic           pick_any_s;
    logic [7:0]     hold_data_r;
    logic           hold_full_r;
    logic [CW-1:0]  cnt_r, cnt_nxt_s;
    logic [7:0]     data_arr_s [NUM_REQ];
    logic           g_valid_s, g_last_s, capture_s, tx_xfer_s, idle_cyc_s, tmo_hit_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_r),
        .winner (pick_idx_s),
        .any    (pick_any_s)
    );

    // Granted-source view, handshake terms and timeout detection.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr_s[i] = req_data[8*i +: 8];
            req_ready[i]  = (state_r == ST_XFER) && !hold_full_r && (grant_r == IDW'(i));
        end
        g_valid_s   = req_valid[grant_r];
        g_last_s    = req_last[grant_r];
        capture_s   = (state_r == ST_XFER) && !hold_full_r && g_valid_s;
        tx_xfer_s   = hold_full_r && tx_data_ready;
        idle_cyc_s  = (state_r == ST_XFER) && !hold_full_r && !g_valid_s;
        tmo_hit_s   = idle_cyc_s && (cnt_r == CW'(TIMEOUT_CYC - 1));
        // Explicit wrap so non-power-of-two NUM_REQ never yields an unused index.
        grant_inc_s = (grant_r == IDW'(NUM_REQ - 1)) ? '0 : grant_r + IDW'(1);
    end

    // Next-state, grant, pointer and idle-counter logic.
    always_comb begin
        state_nxt_s  = state_r;
        grant_nxt_s  = grant_r;
        rr_ptr_nxt_s = rr_ptr_r;
        cnt_nxt_s    = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = '0;
                if (pick_any_s) begin
                    state_nxt_s = ST_XFER;
                    grant_nxt_s = pick_idx_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (capture_s) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = g_last_s ? ST_DRAIN : ST_XFER;
                end else if (tmo_hit_s) begin
                    cnt_nxt_s    = '0;
                    state_nxt_s  = ST_IDLE;
                    rr_ptr_nxt_s = grant_inc_s;
                end else if (idle_cyc_s) begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_DRAIN: begin
                cnt_nxt_s = '0;
                if (tx_xfer_s) begin
                    state_nxt_s  = ST_IDLE;
                    rr_ptr_nxt_s = grant_inc_s;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State, grant, pointer and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            grant_r  <= '0;
            rr_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            state_r  <= state_nxt_s;
            grant_r  <= grant_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    // One-byte holding register; capture only when empty at cycle start (no bypass).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data_r <= 8'h00;
            hold_full_r <= 1'b0;
        end else if (capture_s) begin
            hold_data_r <= data_arr_s[grant_r];
            hold_full_r <= 1'b1;
        end else if (tx_xfer_s) begin
            hold_full_r <= 1'b0;
        end else begin
            hold_full_r <= hold_full_r;
        end
    end

    assign tx_data       = hold_data_r;
    assign tx_data_valid = hold_full_r;
    assign grant_id      = grant_r;
    assign busy          = (state_r != ST_IDLE);
    assign msg_done      = (state_r == ST_DRAIN) && tx_xfer_s;
    assign timeout_err   = tmo_hit_s;

endmodule

// File: tb/tb_uart_tx_msg_arbiter.sv
// Directed bench for uart_tx_msg_arbiter: cycle vector table plus message-level
// sequences (single source, contention, fairness, timeout, tx stall, mid-message reset).
module tb_uart_tx_msg_arbiter;
    import fish_tank_uart_pkg::*;

    localparam int NR  = 4;
    localparam int IW  = 2;
    localparam int TMO = 40;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid, req_last, req_ready;
    logic [8*NR-1:0] req_data;
    logic [7:0]      tx_data;
    logic            tx_data_valid, tx_data_ready;
    logic [IW-1:0]   grant_id;
    logic            busy, msg_done, timeout_err;

    always #5 clk = ~clk;

    uart_tx_msg_arbiter #(
        .NUM_REQ     (NR),
        .IDW         (IW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .msg_done      (msg_done),
        .timeout_err   (timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // source byte buffers: bit 8 = last
    logic [8:0]    sbuf [NR][0:63];
    int            slen [NR];
    int            spos [NR];
    int            stop_at [NR];
    int            last_cap_edge [NR];
    logic [7:0]    rx_b [0:255];
    logic [IW-1:0] rx_g [0:255];
    logic [IW-1:0] done_g [0:15];
    int            rx_n, done_n, tmo_n, tmo_cyc, cyc;
    logic          stall;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic        txr;
        logic [17:0] exp;   // {ready, txv, txd, gid, busy, done, tmo}
    } vec_t;
    vec_t vt [14];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_msg(int s, string m);
        for (int k = 0; k < m.len(); k++) begin
            sbuf[s][slen[s]] = {1'b0, m[k]};
            slen[s]++;
        end
        sbuf[s][slen[s]] = {1'b0, ASCII_CR};
        slen[s]++;
        sbuf[s][slen[s]] = {1'b1, ASCII_LF};
        slen[s]++;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            if (spos[i] < slen[i] && spos[i] < stop_at[i]) begin
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = sbuf[i][spos[i]][7:0];
                req_last[i]       = sbuf[i][spos[i]][8];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
        tx_data_ready = !stall;
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                spos[i]++;
                last_cap_edge[i] = cyc + 1;
            end
        end
        if (tx_data_valid && tx_data_ready && rx_n < 256) begin
            rx_b[rx_n] = tx_data;
            rx_g[rx_n] = grant_id;
            rx_n++;
        end
        if (msg_done && done_n < 16) begin
            done_g[done_n] = grant_id;
            done_n++;
        end
        if (timeout_err) begin
            tmo_n++;
            tmo_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        #1;
        drive_inputs();
    endtask

    task automatic run_until_done(int want, int budget, string name);
        int k = 0;
        while (done_n < want && k < budget) begin
            cycle();
            k++;
        end
        check(name, done_n, want);
    endtask

    task automatic check_rx(string name, int base, int src, int from, int n);
        for (int j = 0; j < n; j++) begin
            check($sformatf("%s[%0d]", name, j), rx_b[base + j], sbuf[src][from + j][7:0]);
        end
    endtask

    task automatic do_reset(string name);
        rst_n         = 1'b0;
        req_valid     = '0;
        req_data      = '0;
        req_last      = '0;
        stall         = 1'b0;
        tx_data_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            slen[i]    = 0;
            spos[i]    = 0;
            stop_at[i] = 1000;
        end
        for (int j = 0; j < 256; j++) rx_b[j] = 'x;
        rx_n   = 0;
        done_n = 0;
        tmo_n  = 0;
        #2;
        check(name, {req_ready, tx_data, tx_data_valid, grant_id, busy, msg_done, timeout_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int k;
        cyc = 0;
        tmo_cyc = 0;

        vt[0]  = '{4'b0100, 32'h0041_0000, 4'b0000, 1'b1, {4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0}};
        vt[1]  = '{4'b0100, 32'h0041_0000, 4'b0000, 1'b1, {4'b0100, 1'b0, 8'h00, 2'd2, 1'b1, 1'b0, 1'b0}};
        vt[2]  = '{4'b0100, 32'h000A_0000, 4'b0100, 1'b1, {4'b0000, 1'b1, 8'h41, 2'd2, 1'b1, 1'b0, 1'b0}};
        vt[3]  = '{4'b0100, 32'h000A_0000, 4'b0100, 1'b1, {4'b0100, 1'b0, 8'h41, 2'd2, 1'b1, 1'b0, 1'b0}};
        vt[4]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, {4'b0000, 1'b1, 8'h0A, 2'd2, 1'b1, 1'b1, 1'b0}};
        vt[5]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, {4'b0000, 1'b0, 8'h0A, 2'd2, 1'b0, 1'b0, 1'b0}};
        vt[6]  = '{4'b1001, 32'h3300_0030, 4'b1001, 1'b1, {4'b0000, 1'b0, 8'h0A, 2'd2, 1'b0, 1'b0, 1'b0}};
        vt[7]  = '{4'b1001, 32'h3300_0030, 4'b1001, 1'b1, {4'b1000, 1'b0, 8'h0A, 2'd3, 1'b1, 1'b0, 1'b0}};
        vt[8]  = '{4'b0001, 32'h0000_0030, 4'b0001, 1'b0, {4'b0000, 1'b1, 8'h33, 2'd3, 1'b1, 1'b0, 1'b0}};
        vt[9]  = '{4'b0001, 32'h0000_0030, 4'b0001, 1'b1, {4'b0000, 1'b1, 8'h33, 2'd3, 1'b1, 1'b1, 1'b0}};
        vt[10] = '{4'b0001, 32'h0000_0030, 4'b0001, 1'b1, {4'b0000, 1'b0, 8'h33, 2'd3, 1'b0, 1'b0, 1'b0}};
        vt[11] = '{4'b0001, 32'h0000_0030, 4'b0001, 1'b1, {4'b0001, 1'b0, 8'h33, 2'd0, 1'b1, 1'b0, 1'b0}};
        vt[12] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, {4'b0000, 1'b1, 8'h30, 2'd0, 1'b1, 1'b1, 1'b0}};
        vt[13] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, {4'b0000, 1'b0, 8'h30, 2'd0, 1'b0, 1'b0, 1'b0}};

        // cycle-level vectors: latency, rr pointer after message, DRAIN with tx stall
        do_reset("rst_state");
        for (int r = 0; r < 14; r++) begin
            req_valid     = vt[r].v;
            req_data      = vt[r].d;
            req_last      = vt[r].l;
            tx_data_ready = vt[r].txr;
            @(negedge clk);
            check($sformatf("vec%0d", r),
                  {req_ready, tx_data_valid, tx_data, grant_id, busy, msg_done, timeout_err}, vt[r].exp);
            @(posedge clk);
            #1;
        end

        // 1: single source full line
        do_reset("t1_rst");
        load_msg(0, "SpO2:097%");
        drive_inputs();
        run_until_done(1, 200, "t1_done");
        check("t1_len", rx_n, 11);
        check_rx("t1_byte", 0, 0, 0, 11);
        check("t1_tmo", tmo_n, 0);

        // 2: sources 0 and 2 together
        do_reset("t2_rst");
        load_msg(0, "WT:24");
        load_msg(2, "PS:ON");
        drive_inputs();
        run_until_done(2, 300, "t2_done");
        check("t2_len", rx_n, 14);
        check_rx("t2_src0", 0, 0, 0, 7);
        check_rx("t2_src2", 7, 2, 0, 7);
        check("t2_gid0", done_g[0], 0);
        check("t2_gid1", done_g[1], 2);
        check("t2_rxgid", rx_g[8], 2);

        // 3: back-to-back source 1 vs waiting source 3
        do_reset("t3_rst");
        load_msg(1, "A1");
        load_msg(1, "B1");
        load_msg(3, "C3");
        drive_inputs();
        run_until_done(3, 300, "t3_done");
        check("t3_gid0", done_g[0], 1);
        check("t3_gid1", done_g[1], 3);
        check("t3_gid2", done_g[2], 1);
        check_rx("t3_m0", 0, 1, 0, 4);
        check_rx("t3_m1", 4, 3, 0, 4);
        check_rx("t3_m2", 8, 1, 4, 4);

        // 4: granted source stalls after 3 bytes
        do_reset("t4_rst");
        load_msg(0, "ABCDEF");
        stop_at[0] = 3;
        load_msg(1, "Z");
        drive_inputs();
        k = 0;
        while (tmo_n == 0 && k < TMO + 60) begin
            cycle();
            k++;
        end
        check("t4_tmo_n", tmo_n, 1);
        check("t4_tmo_delay", tmo_cyc - last_cap_edge[0], TMO);
        #3;
        check("t4_busy_drop", busy, 1'b0);
        run_until_done(1, 100, "t4_next_done");
        check("t4_next_gid", done_g[0], 1);
        check("t4_len", rx_n, 6);
        check_rx("t4_src0", 0, 0, 0, 3);
        check_rx("t4_src1", 3, 1, 0, 3);
        check("t4_tmo_once", tmo_n, 1);

        // 5: uart_tx busy for 500 cycles mid-message
        do_reset("t5_rst");
        load_msg(0, "HR:072");
        drive_inputs();
        k = 0;
        while (rx_n < 3 && k < 50) begin
            cycle();
            k++;
        end
        check("t5_pre_len", rx_n, 3);
        stall = 1'b1;
        tx_data_ready = 1'b0;
        bad = 0;
        for (int s = 0; s < 500; s++) begin
            cycle();
            if (tx_data_valid !== 1'b1 || tx_data !== 8'h30) bad++;
        end
        check("t5_stall_stable", bad, 0);
        check("t5_stall_len", rx_n, 3);
        stall = 1'b0;
        tx_data_ready = 1'b1;
        run_until_done(1, 100, "t5_done");
        check("t5_len", rx_n, 8);
        check_rx("t5_byte", 0, 0, 0, 8);
        check("t5_tmo", tmo_n, 0);

        // 6: reset during byte 5, then a fresh message
        do_reset("t6_rst");
        load_msg(0, "SpO2:097%");
        drive_inputs();
        k = 0;
        while (rx_n < 4 && k < 50) begin
            cycle();
            k++;
        end
        cycle();
        #2;
        check("t6_pre_valid", tx_data_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_async", {req_ready, tx_data, tx_data_valid, grant_id, busy, msg_done, timeout_err}, 32'd0);
        do_reset("t6_rst_hold");
        load_msg(0, "HR:080");
        drive_inputs();
        run_until_done(1, 100, "t6_done");
        check("t6_len", rx_n, 8);
        check_rx("t6_byte", 0, 0, 0, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
